// File: rtl/resp_demux2_pkg.sv
// ----------------------------------------------------------------------------
// proc_pkg
//   Shared constants for the memory response path.
//   - DEST_OUT1 / DEST_OUT2 : destination tag values carried in the tag FIFO
//   - occ_width()           : width of an occupancy counter that must hold the
//                             values 0..depth inclusive
// ----------------------------------------------------------------------------
package proc_pkg;

    localparam logic DEST_OUT1 = 1'b0;
    localparam logic DEST_OUT2 = 1'b1;

    // One extra bit so that "completely full" (== depth) is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/resp_demux2_if.sv
// ----------------------------------------------------------------------------
// resp_demux2_if
//   Bundles every non-clock/reset signal of resp_demux2.
//   Tag side     : tag_push, tag_sel (in)      tag_full, outstanding (out)
//   Response in  : in_valid, in_data (in)      in_ready (out)
//   Response out : out1_valid/out1_data, out2_valid/out2_data (out)
//                  out1_ready, out2_ready (in)
//   Errors       : err_overflow, err_orphan (out)
//   Modports: master = the environment driving the demux, slave = the demux.
// ----------------------------------------------------------------------------
interface resp_demux2_if
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) ();

    localparam int OCC_W = occ_width(DEPTH);

    logic                  tag_push;
    logic                  tag_sel;
    logic                  tag_full;
    logic [OCC_W-1:0]      outstanding;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    logic                  out1_valid;
    logic [DATA_WIDTH-1:0] out1_data;
    logic                  out1_ready;

    logic                  out2_valid;
    logic [DATA_WIDTH-1:0] out2_data;
    logic                  out2_ready;

    logic                  err_overflow;
    logic                  err_orphan;

    modport master (
        output tag_push, tag_sel, in_valid, in_data, out1_ready, out2_ready,
        input  tag_full, outstanding, in_ready,
        input  out1_valid, out1_data, out2_valid, out2_data,
        input  err_overflow, err_orphan
    );

    modport slave (
        input  tag_push, tag_sel, in_valid, in_data, out1_ready, out2_ready,
        output tag_full, outstanding, in_ready,
        output out1_valid, out1_data, out2_valid, out2_data,
        output err_overflow, err_orphan
    );

endinterface

// File: rtl/resp_demux2_tag_fifo.sv
// ----------------------------------------------------------------------------
// tag_fifo
//   In-order FIFO of 1-bit destination tags, DEPTH entries (power of 2, >= 2).
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : push request; taken when not full, or when full and a pop
//               happens in the same cycle (the pop frees the slot)
//   din_i     : tag to push
//   pop_i     : pop request; ignored when empty
//   head_o    : tag at the read pointer (meaningful only when !empty_o)
//   full_o    : count == DEPTH
//   empty_o   : count == 0
//   count_o   : occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module tag_fifo
    import proc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic                        din_i,
    input  logic                        pop_i,
    output logic                        head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [occ_width(DEPTH)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers are exactly log2(DEPTH) bits, so they wrap at DEPTH for free.
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after it
    // has been written, and leaving it out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/resp_demux2.sv
// ----------------------------------------------------------------------------
// resp_demux2
//   Routes a single in-order memory response stream to one of two requesters,
//   using a FIFO of destination tags recorded when each request was issued.
//   One registered output stage {hold_valid, hold_sel, hold_data}.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : resp_demux2_if.slave (tag side, response in, two response
//              outputs, sticky error flags)
//   Optional feature: define RESP_DEMUX_ERR_EN to build the sticky
//   err_overflow / err_orphan flags; otherwise both outputs are tied to 0.
// ----------------------------------------------------------------------------
module resp_demux2
    import proc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    resp_demux2_if.slave     bus
);

    localparam int OCC_W = occ_width(DEPTH);

    logic                  fifo_head, fifo_full, fifo_empty;
    logic [OCC_W-1:0]      fifo_count;

    logic                  hold_valid_q, hold_valid_d;
    logic                  hold_sel_q,   hold_sel_d;
    logic [DATA_WIDTH-1:0] hold_data_q,  hold_data_d;

    logic                  fire, in_ready, accept, load;

    tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.tag_push),
        .din_i   (bus.tag_sel),
        .pop_i   (load),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.tag_full    = fifo_full;
    assign bus.outstanding = fifo_count;

    // Only the ready of the currently selected output can release the stage.
    assign fire = hold_valid_q &&
                  ((hold_sel_q == DEST_OUT2) ? bus.out2_ready : bus.out1_ready);

    // With no tag outstanding the response is dropped, so it never needs to
    // wait for the holding register.
    assign in_ready = !hold_valid_q || fire || fifo_empty;
    assign accept   = bus.in_valid && in_ready;
    assign load     = accept && !fifo_empty;

    // NOTE: every variable gets its default first, so no path through the
    // block leaves a value unassigned and no latch is inferred.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_sel_d   = hold_sel_q;
        hold_data_d  = hold_data_q;
        if (load) begin
            hold_valid_d = 1'b1;
            hold_sel_d   = fifo_head;
            hold_data_d  = bus.in_data;
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_sel_q   <= DEST_OUT1;
            hold_data_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_sel_q   <= hold_sel_d;
            hold_data_q  <= hold_data_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out1_valid = hold_valid_q && (hold_sel_q == DEST_OUT1);
    assign bus.out2_valid = hold_valid_q && (hold_sel_q == DEST_OUT2);
    assign bus.out1_data  = hold_data_q;
    assign bus.out2_data  = hold_data_q;

`ifdef RESP_DEMUX_ERR_EN
    logic err_overflow_q, err_orphan_q;

    // A push while full is only an overflow if no pop frees a slot this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_overflow_q <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            if (bus.tag_push && fifo_full && !load) err_overflow_q <= 1'b1;
            if (accept && fifo_empty)               err_orphan_q   <= 1'b1;
        end
    end

    assign bus.err_overflow = err_overflow_q;
    assign bus.err_orphan   = err_orphan_q;
`else
    assign bus.err_overflow = 1'b0;
    assign bus.err_orphan   = 1'b0;
`endif

endmodule

// File: tb/tb_resp_demux2.sv
// ----------------------------------------------------------------------------
// tb_resp_demux2
//   Table-driven bench for resp_demux2 (DATA_WIDTH = 32, DEPTH = 4) plus
//   hand-written sequences for full boundary, async reset, orphan and
//   same-cycle push/response.
// ----------------------------------------------------------------------------
module tb_resp_demux2;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef RESP_DEMUX_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    resp_demux2_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    resp_demux2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          push, sel, iv;
        logic [DW-1:0] data;
        logic          r1, r2;
        logic          e_v1, e_v2;
        logic [DW-1:0] e_data;
        logic          e_rdy, e_full;
        logic [2:0]    e_occ;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic push, input logic sel, input logic iv,
                         input logic [DW-1:0] data, input logic r1, input logic r2);
        bus.tag_push   = push;
        bus.tag_sel    = sel;
        bus.in_valid   = iv;
        bus.in_data    = data;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
    endtask

    // Advance to the next falling edge, apply inputs, settle.
    task automatic step(input logic push, input logic sel, input logic iv,
                        input logic [DW-1:0] data, input logic r1, input logic r2);
        @(negedge clk);
        drive(push, sel, iv, data, r1, r2);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic v1, input logic v2,
                              input logic [DW-1:0] d, input logic rdy,
                              input logic full, input logic [2:0] occ);
        check({tag, "_o1v"},  32'(bus.out1_valid),  32'(v1));
        check({tag, "_o2v"},  32'(bus.out2_valid),  32'(v2));
        check({tag, "_o1d"},  bus.out1_data,        d);
        check({tag, "_o2d"},  bus.out2_data,        d);
        check({tag, "_rdy"},  32'(bus.in_ready),    32'(rdy));
        check({tag, "_full"}, 32'(bus.tag_full),    32'(full));
        check({tag, "_occ"},  32'(bus.outstanding), 32'(occ));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(logic push, logic sel, logic iv, logic [DW-1:0] data,
                                logic r1, logic r2, logic v1, logic v2,
                                logic [DW-1:0] ed, logic rdy, logic full, logic [2:0] occ);
        vec_t v;
        v.push = push; v.sel = sel; v.iv = iv; v.data = data; v.r1 = r1; v.r2 = r2;
        v.e_v1 = v1; v.e_v2 = v2; v.e_data = ed; v.e_rdy = rdy; v.e_full = full;
        v.e_occ = occ;
        return v;
    endfunction

    initial begin
        // Expectations describe outputs during the cycle the inputs are applied.
        //              push sel iv data   r1 r2 | v1 v2 data  rdy full occ
        // interleaved routing 0,1,1,0 -> A,B,C,D
        vecs[0]  = mk(1, 0, 0, 32'h0,  1, 1,  0, 0, 32'h0,  1, 0, 0);
        vecs[1]  = mk(1, 1, 0, 32'h0,  1, 1,  0, 0, 32'h0,  1, 0, 1);
        vecs[2]  = mk(1, 1, 0, 32'h0,  1, 1,  0, 0, 32'h0,  1, 0, 2);
        vecs[3]  = mk(1, 0, 0, 32'h0,  1, 1,  0, 0, 32'h0,  1, 0, 3);
        vecs[4]  = mk(0, 0, 1, 32'hA,  1, 1,  0, 0, 32'h0,  1, 1, 4);
        vecs[5]  = mk(0, 0, 1, 32'hB,  1, 1,  1, 0, 32'hA,  1, 0, 3);
        vecs[6]  = mk(0, 0, 1, 32'hC,  1, 1,  0, 1, 32'hB,  1, 0, 2);
        vecs[7]  = mk(0, 0, 1, 32'hD,  1, 1,  0, 1, 32'hC,  1, 0, 1);
        vecs[8]  = mk(0, 0, 0, 32'h0,  1, 1,  1, 0, 32'hD,  1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 32'h0,  1, 1,  0, 0, 32'hD,  1, 0, 0);
        // backpressure on out2 with tags 1,0 pending
        vecs[10] = mk(1, 1, 0, 32'h0,  1, 0,  0, 0, 32'hD,  1, 0, 0);
        vecs[11] = mk(1, 0, 0, 32'h0,  1, 0,  0, 0, 32'hD,  1, 0, 1);
        vecs[12] = mk(0, 0, 1, 32'h11, 1, 0,  0, 0, 32'hD,  1, 0, 2);
        vecs[13] = mk(0, 0, 1, 32'h22, 1, 0,  0, 1, 32'h11, 0, 0, 1);
        vecs[14] = mk(0, 0, 1, 32'h22, 1, 0,  0, 1, 32'h11, 0, 0, 1);
        vecs[15] = mk(0, 0, 1, 32'h22, 1, 1,  0, 1, 32'h11, 1, 0, 1);
        vecs[16] = mk(0, 0, 0, 32'h0,  0, 1,  1, 0, 32'h22, 1, 0, 0);
        vecs[17] = mk(0, 0, 0, 32'h0,  1, 1,  1, 0, 32'h22, 1, 0, 0);
        vecs[18] = mk(0, 0, 0, 32'h0,  1, 1,  0, 0, 32'h22, 1, 0, 0);

        // ---- power-on reset ----
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_outs("rst", 0, 0, 32'h0, 1, 0, 0);
        check("rst_eov", 32'(bus.err_overflow), 32'(1'b0));
        check("rst_eor", 32'(bus.err_orphan),   32'(1'b0));
        rst = 1'b0;

        // ---- table ----
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].push, vecs[i].sel, vecs[i].iv, vecs[i].data, vecs[i].r1, vecs[i].r2);
            check_outs($sformatf("v%0d", i), vecs[i].e_v1, vecs[i].e_v2, vecs[i].e_data,
                       vecs[i].e_rdy, vecs[i].e_full, vecs[i].e_occ);
        end

        // ---- full boundary: tags 0,1,0,1 then overflow, then push+pop ----
        do_reset();
        step(1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 0, 32'h0, 1, 1);
        step(1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 0, 32'h0, 1, 1);
        check("full_occ3", 32'(bus.outstanding), 32'd3);
        step(1, 0, 0, 32'h0, 1, 1);               // 5th push while full
        check("full_flag", 32'(bus.tag_full),    32'd1);
        check("full_occ4", 32'(bus.outstanding), 32'd4);
        step(1, 1, 1, 32'hE0, 1, 1);              // push tag 1 + response
        check("ovf_occ",   32'(bus.outstanding), 32'd4);
        check("ovf_err",   32'(bus.err_overflow), 32'(ERR_EN));
        check("ovf_rdy",   32'(bus.in_ready),    32'd1);
        step(0, 0, 1, 32'hE1, 1, 1);
        check_outs("pp0", 1, 0, 32'hE0, 1, 1, 4);
        step(0, 0, 1, 32'hE2, 1, 1);
        check_outs("pp1", 0, 1, 32'hE1, 1, 0, 3);
        step(0, 0, 1, 32'hE3, 1, 1);
        check_outs("pp2", 1, 0, 32'hE2, 1, 0, 2);
        step(0, 0, 1, 32'hE4, 1, 1);
        check_outs("pp3", 0, 1, 32'hE3, 1, 0, 1);
        step(0, 0, 0, 32'h0, 1, 1);
        check_outs("pp4", 0, 1, 32'hE4, 1, 0, 0);
        check("pp4_eov", 32'(bus.err_overflow), 32'(ERR_EN));

        // ---- asynchronous reset mid-stream ----
        do_reset();
        step(1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 0, 32'h0, 1, 1);
        step(0, 0, 1, 32'h77, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0);
        check("mid_pre_v1", 32'(bus.out1_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_outs("mid_async", 0, 0, 32'h0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs("mid_rst", 0, 0, 32'h0, 1, 0, 0);

        // ---- orphan response ----
        step(0, 0, 1, 32'h55, 1, 1);
        check("orph_rdy", 32'(bus.in_ready), 32'd1);
        step(0, 0, 0, 32'h0, 1, 1);
        check_outs("orph", 0, 0, 32'h0, 1, 0, 0);
        check("orph_err", 32'(bus.err_orphan),   32'(ERR_EN));
        check("orph_eov", 32'(bus.err_overflow), 32'd0);

        // ---- same-cycle push + response with empty FIFO ----
        do_reset();
        step(1, 0, 1, 32'h66, 1, 1);
        check("sc_rdy", 32'(bus.in_ready), 32'd1);
        step(0, 0, 0, 32'h0, 1, 1);
        check_outs("sc", 0, 0, 32'h0, 1, 0, 1);
        check("sc_err", 32'(bus.err_orphan), 32'(ERR_EN));
        step(0, 0, 1, 32'h88, 1, 1);
        step(0, 0, 0, 32'h0, 1, 1);
        check_outs("sc_tag", 1, 0, 32'h88, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
